// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register_file_rd slice.
//   fun_e   - 2-bit register function codes (decrement, increment, load, clear)
//   R1..S4  - register indices as used in regSel bit positions and read selects
//   WIDTH   - default data width, NREG - register count
package regfile_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NREG  = 8;

    typedef enum logic [1:0] {
        FS_DEC  = 2'b00,
        FS_INC  = 2'b01,
        FS_LOAD = 2'b10,
        FS_CLR  = 2'b11
    } fun_e;

    localparam int unsigned R1 = 0;
    localparam int unsigned R2 = 1;
    localparam int unsigned R3 = 2;
    localparam int unsigned R4 = 3;
    localparam int unsigned S1 = 4;
    localparam int unsigned S2 = 5;
    localparam int unsigned S3 = 6;
    localparam int unsigned S4 = 7;

endpackage

// File: rtl/reg16_async.sv
// reg16_async: one register with the standard four-function set.
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low clear
//   enable  - when high, funSel is applied at the edge; otherwise hold
//   funSel  - FS_DEC / FS_INC / FS_LOAD / FS_CLR
//   i       - load data
//   o       - current register contents
module reg16_async
    import regfile_pkg::*;
#(
    parameter int unsigned W = WIDTH
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         enable,
    input  logic [1:0]   funSel,
    input  logic [W-1:0] i,
    output logic [W-1:0] o
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            o <= '0;
        end else if (enable) begin
            case (fun_e'(funSel))
                FS_DEC:  o <= o - 1'b1;
                FS_INC:  o <= o + 1'b1;
                FS_LOAD: o <= i;
                FS_CLR:  o <= '0;
                default: o <= o;
            endcase
        end
    end

endmodule

// File: rtl/register_file_rd.sv
// register_file_rd: eight registers (R1..R4, S1..S4) with two combinational
// read ports feeding the ALU operand buses.
//   clock, reset_n   - rising-edge clock, asynchronous active-low clear
//   i                - load data shared by all registers
//   funSel           - function applied to every register enabled in regSel
//   regSel           - per-register write enable mask (bit k -> register k)
//   outASel, outBSel - read selects
//   outA, outB       - selected register contents (no write-through bypass)
//   zeroA            - high when outA is zero
module register_file_rd
    import regfile_pkg::*;
#(
    parameter int unsigned W  = WIDTH,
    parameter int unsigned NR = NREG
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [W-1:0]  i,
    input  logic [1:0]    funSel,
    input  logic [NR-1:0] regSel,
    input  logic [2:0]    outASel,
    input  logic [2:0]    outBSel,
    output logic [W-1:0]  outA,
    output logic [W-1:0]  outB,
    output logic          zeroA
);

    logic [W-1:0] regs [NR];

    for (genvar k = 0; k < NR; k++) begin : g_reg
        reg16_async #(.W(W)) u_reg (
            .clock   (clock),
            .reset_n (reset_n),
            .enable  (regSel[k]),
            .funSel  (funSel),
            .i       (i),
            .o       (regs[k])
        );
    end

    always_comb begin
        outA  = regs[outASel];
        outB  = regs[outBSel];
        zeroA = (outA == '0);
    end

endmodule

// File: tb/tb_register_file_rd.sv
module tb_register_file_rd;

    logic        clock;
    logic        reset_n;
    logic [15:0] i;
    logic [1:0]  funSel;
    logic [7:0]  regSel;
    logic [2:0]  outASel;
    logic [2:0]  outBSel;
    logic [15:0] outA;
    logic [15:0] outB;
    logic        zeroA;

    int total = 0;
    int bad   = 0;

    register_file_rd dut (
        .clock   (clock),
        .reset_n (reset_n),
        .i       (i),
        .funSel  (funSel),
        .regSel  (regSel),
        .outASel (outASel),
        .outBSel (outBSel),
        .outA    (outA),
        .outB    (outB),
        .zeroA   (zeroA)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // read register k through port A (only used while regSel = 0)
    task automatic rd(input string tag, input logic [2:0] k, input logic [15:0] exp);
        outASel = k;
        #1;
        chk(tag, outA, exp);
    endtask

    initial begin
        reset_n = 1'b0;
        i       = 16'h0000;
        funSel  = 2'b00;
        regSel  = 8'h00;
        outASel = 3'd0;
        outBSel = 3'd7;

        // reset state
        #12;
        chk("rst_outA", outA, 16'h0000);
        chk("rst_outB", outB, 16'h0000);
        chk("rst_zeroA", {15'd0, zeroA}, 16'h0001);
        #5 reset_n = 1'b1;
        step();
        step();
        chk("idle_outA", outA, 16'h0000);
        chk("idle_outB", outB, 16'h0000);

        // load R1 = 1234
        regSel = 8'b0000_0001; funSel = 2'b10; i = 16'h1234;
        step();
        regSel = 8'h00;
        rd("load_R1", 3'd0, 16'h1234);
        chk("load_R1_zeroA", {15'd0, zeroA}, 16'h0000);

        // load S4 = ABCD, R1 untouched
        regSel = 8'b1000_0000; i = 16'hABCD;
        step();
        regSel = 8'h00;
        #1;
        chk("load_S4_outB", outB, 16'hABCD);
        rd("R1_kept", 3'd0, 16'h1234);

        // R2: clear, decrement wrap, increment wrap
        regSel = 8'b0000_0010; funSel = 2'b11;
        step();
        outASel = 3'd1; #1;
        chk("clr_R2", outA, 16'h0000);
        chk("clr_R2_zeroA", {15'd0, zeroA}, 16'h0001);
        funSel = 2'b00;
        step();
        chk("dec_wrap_R2", outA, 16'hFFFF);
        funSel = 2'b01;
        step();
        chk("inc_wrap_R2", outA, 16'h0000);

        // R3: load FFFF then increment wraps
        regSel = 8'b0000_0100; funSel = 2'b10; i = 16'hFFFF;
        step();
        outASel = 3'd2; #1;
        chk("load_R3", outA, 16'hFFFF);
        funSel = 2'b01;
        step();
        chk("inc_wrap_R3", outA, 16'h0000);

        // multi-select decrement
        regSel = 8'b0000_0001; funSel = 2'b10; i = 16'h0002;
        step();
        regSel = 8'b1000_0000; i = 16'h0010;
        step();
        regSel = 8'b1000_0001; funSel = 2'b00;
        step();
        regSel = 8'h00;
        rd("multi_R1", 3'd0, 16'h0001);
        rd("multi_R2", 3'd1, 16'h0000);
        rd("multi_R3", 3'd2, 16'h0000);
        rd("multi_R4", 3'd3, 16'h0000);
        rd("multi_S1", 3'd4, 16'h0000);
        rd("multi_S4", 3'd7, 16'h000F);

        // regSel = 0: nothing changes even with clear and load data present
        regSel = 8'h00; funSel = 2'b11; i = 16'h7777;
        step();
        rd("hold_R1", 3'd0, 16'h0001);
        rd("hold_S4", 3'd7, 16'h000F);

        // read during write of R3 (old 0003 -> 5555), both ports on R3
        regSel = 8'b0000_0100; funSel = 2'b10; i = 16'h0003;
        step();
        outASel = 3'd2; outBSel = 3'd2; i = 16'h5555;
        #1;
        chk("rdw_before_A", outA, 16'h0003);
        chk("rdw_before_B", outB, 16'h0003);
        step();
        chk("rdw_after_A", outA, 16'h5555);
        chk("rdw_after_B", outB, 16'h5555);

        // async reset mid-operation
        regSel = 8'hFF; funSel = 2'b10; i = 16'h00F0;
        step();
        funSel = 2'b01;
        step();
        outASel = 3'd5; outBSel = 3'd6; #1;
        chk("inc_all_A", outA, 16'h00F1);
        chk("inc_all_B", outB, 16'h00F1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_A", outA, 16'h0000);
        chk("async_rst_B", outB, 16'h0000);
        chk("async_rst_zeroA", {15'd0, zeroA}, 16'h0001);
        step();
        regSel = 8'h00;
        #2 reset_n = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            rd($sformatf("post_rst_%0d", k), 3'(k), 16'h0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
